aha_axi_lite_reg_slave: RTL and testbench

AHA_AXI_LITE_REG_SLAVE -- requirements
Module: aha_axi_lite_reg_slave

---
 rtl/aha_axi_lite_reg_slave.sv | 174 +++++++++++++++++
 tb/tb_aha_axi_lite_reg_slave.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/aha_axi_lite_reg_slave.sv
// AXI4-Lite register slave: NUM_REGS x 32-bit registers with independent AW/W capture and concurrent read path.
// Define AHA_LITE_REG_DECERR_EN to answer out-of-range accesses with DECERR instead of OKAY.
module aha_axi_lite_reg_slave #(
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [31:0]           LITE_AWADDR,
    input  logic                  LITE_AWVALID,
    output logic                  LITE_AWREADY,
    input  logic [31:0]           LITE_WDATA,
    input  logic [3:0]            LITE_WSTRB,
    input  logic                  LITE_WVALID,
    output logic                  LITE_WREADY,
    output logic [1:0]            LITE_BRESP,
    output logic                  LITE_BVALID,
    input  logic                  LITE_BREADY,
    input  logic [31:0]           LITE_ARADDR,
    input  logic                  LITE_ARVALID,
    output logic                  LITE_ARREADY,
    output logic [31:0]           LITE_RDATA,
    output logic [1:0]            LITE_RRESP,
    output logic                  LITE_RVALID,
    input  logic                  LITE_RREADY,
    output logic [NUM_REGS*32-1:0] REG_OUT,
    output logic [NUM_REGS-1:0]   WR_PULSE
);

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AHA_LITE_REG_DECERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b11;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    logic [31:0]         regs_q [NUM_REGS];
    logic [31:0]         regs_d [NUM_REGS];
    logic                aw_held_q, aw_held_d;
    logic [29:0]         awidx_q, awidx_d;
    logic                w_held_q, w_held_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

    logic                aw_hs, w_hs, ar_hs, commit;
    logic [29:0]         wr_idx;
    logic [31:0]         wr_data;
    logic [3:0]          wr_strb;
    logic [NUM_REGS-1:0] wr_hit, rd_hit;
    logic [31:0]         rd_mux;

    // Byte offset bits take no part in decode.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{LITE_AWADDR[1:0], LITE_ARADDR[1:0]};

    assign LITE_AWREADY = ~aw_held_q & ~bvalid_q;
    assign LITE_WREADY  = ~w_held_q & ~bvalid_q;
    assign LITE_ARREADY = ~rvalid_q;
    assign LITE_BVALID  = bvalid_q;
    assign LITE_BRESP   = bresp_q;
    assign LITE_RVALID  = rvalid_q;
    assign LITE_RDATA   = rdata_q;
    assign LITE_RRESP   = rresp_q;
    assign WR_PULSE     = wr_pulse_q;

    assign aw_hs  = LITE_AWVALID & LITE_AWREADY;
    assign w_hs   = LITE_WVALID & LITE_WREADY;
    assign ar_hs  = LITE_ARVALID & LITE_ARREADY;
    assign commit = (aw_held_q | aw_hs) & (w_held_q | w_hs);

    // Held copies win; a live handshake is only possible when nothing is held.
    assign wr_idx  = aw_held_q ? awidx_q : LITE_AWADDR[31:2];
    assign wr_data = w_held_q ? wdata_q : LITE_WDATA;
    assign wr_strb = w_held_q ? wstrb_q : LITE_WSTRB;

    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit[i] = (wr_idx == 30'(i));
            rd_hit[i] = (LITE_ARADDR[31:2] == 30'(i));
            if (rd_hit[i]) rd_mux = regs_q[i];
        end
    end

    always_comb begin
        regs_d     = regs_q;
        aw_held_d  = aw_held_q;
        awidx_d    = awidx_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        wr_pulse_d = '0;

        if (bvalid_q && LITE_BREADY) bvalid_d = 1'b0;

        if (commit) begin
            aw_held_d  = 1'b0;
            w_held_d   = 1'b0;
            bvalid_d   = 1'b1;
            bresp_d    = (|wr_hit) ? RESP_OKAY : RESP_OOR;
            wr_pulse_d = wr_hit;
            for (int i = 0; i < NUM_REGS; i++)
                for (int k = 0; k < 4; k++)
                    if (wr_hit[i] && wr_strb[k]) regs_d[i][8*k +: 8] = wr_data[8*k +: 8];
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                awidx_d   = LITE_AWADDR[31:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = LITE_WDATA;
                wstrb_d  = LITE_WSTRB;
            end
        end

        // Read samples regs_q, so a same-edge commit returns the old value.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
            rresp_d  = (|rd_hit) ? RESP_OKAY : RESP_OOR;
        end else if (rvalid_q && LITE_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
            aw_held_q  <= 1'b0;
            awidx_q    <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            wr_pulse_q <= '0;
        end else begin
            regs_q     <= regs_d;
            aw_held_q  <= aw_held_d;
            awidx_q    <= awidx_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign REG_OUT[32*g +: 32] = regs_q[g];
    end

endmodule

// File: tb/tb_aha_axi_lite_reg_slave.sv
// Directed self-checking bench for aha_axi_lite_reg_slave (NUM_REGS=8, RESET_VAL=0).
module tb_aha_axi_lite_reg_slave;

    localparam int NR = 8;
`ifdef AHA_LITE_REG_DECERR_EN
    localparam logic [1:0] EXP_OOR = 2'b11;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic [31:0]   AWADDR, WDATA, ARADDR;
    logic [3:0]    WSTRB;
    logic          AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic          AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]    BRESP, RRESP;
    logic [31:0]   RDATA;
    logic [NR*32-1:0] REG_OUT;
    logic [NR-1:0] WR_PULSE;

    logic [NR*32-1:0] exp_regs;
    int npass = 0;
    int ntot  = 0;

    aha_axi_lite_reg_slave #(.NUM_REGS(NR), .RESET_VAL(32'h0)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .LITE_AWADDR(AWADDR), .LITE_AWVALID(AWVALID), .LITE_AWREADY(AWREADY),
        .LITE_WDATA(WDATA), .LITE_WSTRB(WSTRB), .LITE_WVALID(WVALID), .LITE_WREADY(WREADY),
        .LITE_BRESP(BRESP), .LITE_BVALID(BVALID), .LITE_BREADY(BREADY),
        .LITE_ARADDR(ARADDR), .LITE_ARVALID(ARVALID), .LITE_ARREADY(ARREADY),
        .LITE_RDATA(RDATA), .LITE_RRESP(RRESP), .LITE_RVALID(RVALID), .LITE_RREADY(RREADY),
        .REG_OUT(REG_OUT), .WR_PULSE(WR_PULSE)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        AWADDR = a; AWVALID = 1'b1; WDATA = d; WSTRB = s; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        ntot++; if (BVALID !== 1'b0) $display("FAIL rst_bvalid got %0b exp 0", BVALID); else npass++;
        ntot++; if (RVALID !== 1'b0) $display("FAIL rst_rvalid got %0b exp 0", RVALID); else npass++;
        ntot++; if (REG_OUT !== '0) $display("FAIL rst_regout got %h exp 0", REG_OUT); else npass++;
        ntot++; if (WR_PULSE !== '0 || RDATA !== 32'h0) $display("FAIL rst_pulse_rdata got %h/%h exp 0/0", WR_PULSE, RDATA); else npass++;
        tick();
        ARESETn = 1'b1;
        ntot++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) $display("FAIL rst_readys got %b exp 111", {AWREADY, WREADY, ARREADY}); else npass++;
    endtask

    task automatic test_aw_w_same();
        AWADDR = 32'h4; AWVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        exp_regs[63:32] = 32'hDEADBEEF;
        ntot++; if (BVALID !== 1'b1 || BRESP !== 2'b00) $display("FAIL same_b got %0b/%b exp 1/00", BVALID, BRESP); else npass++;
        ntot++; if (WR_PULSE !== 8'b0000_0010) $display("FAIL same_pulse got %b exp 00000010", WR_PULSE); else npass++;
        ntot++; if (REG_OUT !== exp_regs) $display("FAIL same_regout got %h exp %h", REG_OUT, exp_regs); else npass++;
        ntot++; if ({AWREADY, WREADY} !== 2'b00) $display("FAIL same_ready_busy got %b exp 00", {AWREADY, WREADY}); else npass++;
        tick();
        ntot++; if (WR_PULSE !== 8'h0 || BVALID !== 1'b1) $display("FAIL same_hold got %b/%0b exp 0/1", WR_PULSE, BVALID); else npass++;
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        ntot++; if (BVALID !== 1'b0) $display("FAIL same_bclr got %0b exp 0", BVALID); else npass++;
    endtask

    task automatic test_w_first();
        WDATA = 32'h12345678; WSTRB = 4'h5; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        ntot++; if (WREADY !== 1'b0 || BVALID !== 1'b0) $display("FAIL wfirst_held got %0b/%0b exp 0/0", WREADY, BVALID); else npass++;
        tick();
        tick();
        AWADDR = 32'h8; AWVALID = 1'b1;
        ntot++; if (AWREADY !== 1'b1) $display("FAIL wfirst_awready got %0b exp 1", AWREADY); else npass++;
        tick();
        AWVALID = 1'b0;
        exp_regs[95:64] = 32'h00340078;
        ntot++; if (BVALID !== 1'b1 || WR_PULSE !== 8'b0000_0100) $display("FAIL wfirst_commit got %0b/%b exp 1/00000100", BVALID, WR_PULSE); else npass++;
        ntot++; if (REG_OUT !== exp_regs) $display("FAIL wfirst_regout got %h exp %h", REG_OUT, exp_regs); else npass++;
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        ntot++; if ({AWREADY, WREADY} !== 2'b11) $display("FAIL wfirst_ready_back got %b exp 11", {AWREADY, WREADY}); else npass++;
    endtask

    task automatic test_read_stall();
        do_write(32'hC, 32'hA5A50003, 4'hF);
        exp_regs[127:96] = 32'hA5A50003;
        ARADDR = 32'hC; ARVALID = 1'b1; RREADY = 1'b0;
        tick();
        ARVALID = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ntot++;
            if (RVALID !== 1'b1 || RDATA !== 32'hA5A50003 || RRESP !== 2'b00 || ARREADY !== 1'b0)
                $display("FAIL rd_stall_c%0d got v=%0b d=%h r=%b ar=%0b exp 1/a5a50003/00/0", c, RVALID, RDATA, RRESP, ARREADY);
            else npass++;
            tick();
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        ntot++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) $display("FAIL rd_done got %0b/%0b exp 0/1", RVALID, ARREADY); else npass++;
    endtask

    task automatic test_out_of_range();
        AWADDR = 32'h40; AWVALID = 1'b1; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        ntot++; if (BVALID !== 1'b1 || BRESP !== EXP_OOR) $display("FAIL oor_wr got %0b/%b exp 1/%b", BVALID, BRESP, EXP_OOR); else npass++;
        ntot++; if (WR_PULSE !== 8'h0 || REG_OUT !== exp_regs) $display("FAIL oor_state got %b/%h exp 0/%h", WR_PULSE, REG_OUT, exp_regs); else npass++;
        BREADY = 1'b1; ARADDR = 32'h40; ARVALID = 1'b1;
        tick();
        BREADY = 1'b0; ARVALID = 1'b0;
        ntot++; if (RVALID !== 1'b1 || RDATA !== 32'h0 || RRESP !== EXP_OOR) $display("FAIL oor_rd got %0b/%h/%b exp 1/0/%b", RVALID, RDATA, RRESP, EXP_OOR); else npass++;
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
    endtask

    task automatic test_same_edge();
        do_write(32'hC, 32'h1, 4'hF);
        ARADDR = 32'hC; ARVALID = 1'b1;
        AWADDR = 32'hC; AWVALID = 1'b1; WDATA = 32'h2; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
        exp_regs[127:96] = 32'h2;
        ntot++; if (RDATA !== 32'h1 || RVALID !== 1'b1) $display("FAIL edge_rdata got %h/%0b exp 1/1", RDATA, RVALID); else npass++;
        ntot++; if (REG_OUT !== exp_regs || WR_PULSE !== 8'b0000_1000) $display("FAIL edge_reg got %h/%b exp %h/00001000", REG_OUT, WR_PULSE, exp_regs); else npass++;
        BREADY = 1'b1; RREADY = 1'b1;
        tick();
        BREADY = 1'b0; RREADY = 1'b0;
    endtask

    task automatic test_strb_zero();
        do_write(32'h6, 32'h0BADF00D, 4'h0);
        ntot++; if (REG_OUT !== exp_regs) $display("FAIL strb0_regout got %h exp %h", REG_OUT, exp_regs); else npass++;
        do_write(32'h5, 32'hAABBCCDD, 4'b1010);
        exp_regs[63:32] = 32'hAAADCCEF;
        ntot++; if (REG_OUT !== exp_regs) $display("FAIL strb_a_regout got %h exp %h", REG_OUT, exp_regs); else npass++;
    endtask

    task automatic test_reset_mid();
        AWADDR = 32'h18; AWVALID = 1'b1; WDATA = 32'h66; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        ntot++; if (BVALID !== 1'b1) $display("FAIL mid_bpend got %0b exp 1", BVALID); else npass++;
        ARESETn = 1'b0;
        #2;
        exp_regs = '0;
        ntot++; if (BVALID !== 1'b0 || REG_OUT !== exp_regs || WR_PULSE !== 8'h0) $display("FAIL mid_rst_out got %0b/%h/%b exp 0/0/0", BVALID, REG_OUT, WR_PULSE); else npass++;
        ntot++; if (RDATA !== 32'h0 || BRESP !== 2'b00 || RRESP !== 2'b00) $display("FAIL mid_rst_data got %h/%b/%b exp 0/00/00", RDATA, BRESP, RRESP); else npass++;
        tick();
        ARESETn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            ntot++; if (BVALID !== 1'b0) $display("FAIL mid_noresp_c%0d got %0b exp 0", c, BVALID); else npass++;
        end
        AWADDR = 32'h10; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        ntot++; if (AWREADY !== 1'b0) $display("FAIL mid_awheld got %0b exp 0", AWREADY); else npass++;
        ARESETn = 1'b0;
        #2;
        ntot++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) $display("FAIL mid_rst_ready got %b exp 111", {AWREADY, WREADY, ARREADY}); else npass++;
        tick();
        ARESETn = 1'b1;
        WDATA = 32'h77; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        ntot++; if (BVALID !== 1'b0 || REG_OUT !== exp_regs || WR_PULSE !== 8'h0) $display("FAIL mid_stale_aw got %0b/%h/%b exp 0/0/0", BVALID, REG_OUT, WR_PULSE); else npass++;
        AWADDR = 32'h14; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        exp_regs[191:160] = 32'h77;
        ntot++; if (BVALID !== 1'b1 || REG_OUT !== exp_regs) $display("FAIL mid_recover got %0b/%h exp 1/%h", BVALID, REG_OUT, exp_regs); else npass++;
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    initial begin
        ARESETn = 1'b0;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        exp_regs = '0;
        test_reset();
        test_aw_w_same();
        test_w_first();
        test_read_stall();
        test_out_of_range();
        test_same_edge();
        test_strb_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
